fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Instruction-fetch sequencer on the consumer side of the 8-bit program counter (prgcnt).
- Reads the PC value (add_out) to pick its start address and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Hands non-control instructions downstream over a valid/ready handshake.
- Drives the PC's ld/ld_add port with the next address: sequential, or a jump target.

Parameters:
- AW, 8, address width; matches PC add_out/ld_add.
- DW, 16, instruction width.
- OP_JMP, 4'hF, opcode (instr[15:12]) for an absolute jump; target is instr[AW-1:0].
- OP_HALT, 4'hE, opcode that stops fetching.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching at the current pc; sampled in IDLE and HALTED only.
- pc  in  AW  PC value, connected to prgcnt add_out.
- ld  out  1  one-cycle load strobe to the PC.
- ld_add  out  AW  address to load into the PC; valid while ld=1.
- mem_req  out  1  memory read request.
- mem_addr  out  AW  read address; stable while mem_req=1.
- mem_ack  in  1  memory read done; mem_rdata is valid in the same cycle.
- mem_rdata  in  DW  instruction word.
- instr_valid  out  1  downstream instruction valid.
- instr  out  DW  downstream instruction; stable while instr_valid=1.
- instr_ready  in  1  downstream accepts the instruction.
- halted  out  1  high while in the HALTED state.
- issue_cnt  out  8  count of instructions accepted downstream; wraps at 8'hFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - ld, mem_req, instr_valid and halted are 0.
  - ld_add, mem_addr, instr, issue_cnt and the internal fetch address fa are 0.
- IDLE: if start=1, then fa<=pc and go to FETCH.
- FETCH:
  - mem_req=1 and mem_addr=fa.
  - Hold until mem_ack=1 is sampled. Zero-wait memory may ack in the first FETCH cycle.
  - On ack, ir<=mem_rdata and mem_req drops in the next cycle. Decode ir[15:12]:
    - OP_JMP: nxt<=ir[AW-1:0], go to LOAD. Not issued downstream.
    - OP_HALT: go to HALTED. Not issued; fa is unchanged.
    - Any other opcode: go to ISSUE.
- ISSUE:
  - instr_valid=1 and instr=ir.
  - On instr_valid&&instr_ready: issue_cnt<=issue_cnt+1, nxt<=fa+1 (modulo 2^AW, so 8'hFF wraps to 8'h00), go to LOAD.
  - instr_valid stays high and instr stays stable until accepted.
- LOAD:
  - Exactly one cycle with ld=1 and ld_add=nxt.
  - fa<=nxt, go to FETCH. mem_addr then equals the value just loaded into the PC.
- HALTED:
  - halted=1.
  - If start=1, then halted<=0, fa<=pc and go to FETCH.
- start is ignored in FETCH, ISSUE and LOAD.
- ld is never asserted outside LOAD; mem_req and instr_valid are never high in the same cycle.
- Throughput with zero-wait memory and ready tied high:
  - non-jump instruction: 3 cycles (FETCH, ISSUE, LOAD).
  - jump: 2 cycles (FETCH, LOAD).
- Latency: start sampled at edge k gives mem_req=1 in cycle k+1.
- Reset mid-operation:
  - Outputs clear immediately, with no completion of the pending memory or downstream handshake.
  - Memory must tolerate mem_req dropping without an ack.

Test Plan:
- Reset: hold rst=0 with random inputs -> every output is 0 and state is IDLE. Release rst and keep start=0 for 10 cycles -> no mem_req and no ld.
- Sequential fetch: pc=8'h0A, pulse start. Memory returns 16'h1234, 16'h2345 with zero wait, ready=1 -> mem_addr 0A then 0B; ld pulses with ld_add=0B, then 0C; instr 1234, 2345 issued; issue_cnt=2.
- Jump: mem[0A]=16'hF040 -> no instr_valid, one ld pulse with ld_add=40, next mem_addr=40, issue_cnt unchanged.
- Back-pressure and wait states:
  - mem_ack delayed 3 cycles -> mem_req and mem_addr held steady.
  - instr_ready low for 4 cycles -> instr_valid and instr held; no ld until acceptance.
- Wrap and halt:
  - pc=8'hFF with a non-jump instruction -> ld_add=8'h00.
  - mem[00]=16'hE000 -> halted=1 and no further mem_req.
  - start with pc=8'h20 -> fetch resumes at 20.
- Reset mid-FETCH: assert rst while mem_req=1 and before ack -> mem_req falls with no clock edge. After release and start, fa is taken from the current pc.

Source files
------------

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: fetches from instruction memory at the PC and issues non-control words downstream.
// Latency: start -> mem_req next cycle; 3 cycles/instr (FETCH, ISSUE, LOAD) and 2 cycles/jump with zero-wait memory.
// Backpressure: FETCH holds req until mem_ack; ISSUE holds instr_valid/instr until instr_ready.
module fetch_seq #(
    parameter int          AW      = 8,
    parameter int          DW      = 16,
    parameter logic [3:0]  OP_JMP  = 4'hF,
    parameter logic [3:0]  OP_HALT = 4'hE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] pc,
    output logic          ld,
    output logic [AW-1:0] ld_add,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    input  logic          instr_ready,
    output logic          halted,
    output logic [7:0]    issue_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_LOAD,
        S_HALTED
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] fa;
    logic [AW-1:0] nxt;
    logic [DW-1:0] ir;
    logic [7:0]    cnt;
    logic [3:0]    op;

    // Decode straight off the memory bus so the branch is taken in the ack cycle.
    assign op = mem_rdata[DW-1 -: 4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    if (op == OP_JMP)       state_nxt = S_LOAD;
                    else if (op == OP_HALT) state_nxt = S_HALTED;
                    else                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:  if (instr_ready) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_FETCH;
            S_HALTED: if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fa  <= '0;
            nxt <= '0;
            ir  <= '0;
            cnt <= '0;
        end else begin
            if ((state == S_IDLE || state == S_HALTED) && start) begin
                fa <= pc;
            end
            if (state == S_FETCH && mem_ack) begin
                ir <= mem_rdata;
                if (op == OP_JMP) begin
                    nxt <= mem_rdata[AW-1:0];
                end
            end
            if (state == S_ISSUE && instr_ready) begin
                cnt <= cnt + 8'd1;
                nxt <= fa + {{(AW-1){1'b0}}, 1'b1};
            end
            if (state == S_LOAD) begin
                fa <= nxt;
            end
        end
    end

    // Outputs decode from state so an async reset clears them without a clock edge.
    assign mem_req     = (state == S_FETCH);
    assign mem_addr    = fa;
    assign ld          = (state == S_LOAD);
    assign ld_add      = nxt;
    assign instr_valid = (state == S_ISSUE);
    assign instr       = ir;
    assign halted      = (state == S_HALTED);
    assign issue_cnt   = cnt;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: memory model, scoreboard queues for fetch addresses, loads and issued words,
// a table of single-instruction runs plus hand-written sequential, reset and mid-fetch reset sequences.
module tb_fetch_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  pc;
    logic        ld;
    logic [7:0]  ld_add;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        halted;
    logic [7:0]  issue_cnt;

    fetch_seq dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .ld(ld), .ld_add(ld_add),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .halted(halted), .issue_cnt(issue_cnt)
    );

    int checks = 0;
    int errs   = 0;

    logic [15:0] mem [256];
    int          mem_wait = 0;
    int          wcnt     = 0;
    logic [7:0]  exp_cnt  = 8'd0;

    logic [7:0]  q_addr[$];
    logic [7:0]  q_ld[$];
    logic [15:0] q_instr[$];

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] word;
        bit          issue;
        bit          has_ld;
        logic [7:0]  ld_add;
        int          wait_n;
        int          rdy_dly;
    } row_t;

    row_t rows[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: acks after mem_wait cycles of request, data valid with the ack.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst && mem_req) begin
                if (wcnt >= mem_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Scoreboard monitor, sampled late in the low phase when all inputs for the next edge are settled.
    initial begin
        logic        pv_req, pv_iv;
        logic [7:0]  pv_addr;
        logic [15:0] pv_instr;
        pv_req = 1'b0; pv_iv = 1'b0; pv_addr = 8'h00; pv_instr = 16'h0000;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                pv_req = 1'b0;
                pv_iv  = 1'b0;
            end else begin
                if (mem_req && instr_valid) check("req_valid_exclusive", 1, 0);
                if (pv_req) check("mem_hold", {mem_req, mem_addr}, {1'b1, pv_addr});
                if (pv_iv)  check("instr_hold", {instr_valid, instr}, {1'b1, pv_instr});
                if (mem_req && mem_ack) begin
                    if (q_addr.size() == 0) check("unexpected_fetch", mem_addr, 0);
                    else check("fetch_addr", mem_addr, q_addr.pop_front());
                end
                if (ld) begin
                    if (q_ld.size() == 0) check("unexpected_ld", ld_add, 0);
                    else check("ld_add", ld_add, q_ld.pop_front());
                end
                if (instr_valid && instr_ready) begin
                    if (q_instr.size() == 0) check("unexpected_issue", instr, 0);
                    else check("instr", instr, q_instr.pop_front());
                end
                pv_req   = mem_req && !mem_ack;
                pv_addr  = mem_addr;
                pv_iv    = instr_valid && !instr_ready;
                pv_instr = instr;
            end
        end
    end

    task automatic start_pc(input logic [7:0] p);
        pc    = p;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_latency", {mem_req, mem_addr}, {1'b1, p});
    endtask

    task automatic wait_halted(output int n);
        n = 0;
        while (!halted && n < 200) begin
            step();
            n++;
        end
        if (!halted) check("halt_timeout", 0, 1);
    endtask

    task automatic after_halt(input string tag);
        check({tag, "_halted"}, halted, 1);
        check({tag, "_issue_cnt"}, issue_cnt, exp_cnt);
        repeat (3) step();
        check({tag, "_idle_bus"}, {mem_req, ld, instr_valid}, 3'b000);
        check({tag, "_queues_empty"}, q_addr.size() + q_ld.size() + q_instr.size(), 0);
    endtask

    initial begin
        int n;
        rows[0] = '{8'h10, 16'hF040, 1'b0, 1'b1, 8'h40, 0, 0};
        rows[1] = '{8'h50, 16'h0ABC, 1'b1, 1'b1, 8'h51, 3, 0};
        rows[2] = '{8'h20, 16'h7777, 1'b1, 1'b1, 8'h21, 0, 4};
        rows[3] = '{8'hFF, 16'h1111, 1'b1, 1'b1, 8'h00, 0, 0};
        rows[4] = '{8'h30, 16'hF0FF, 1'b0, 1'b1, 8'hFF, 1, 0};
        rows[5] = '{8'h80, 16'hE123, 1'b0, 1'b0, 8'h00, 0, 0};
        rows[6] = '{8'h90, 16'h5A5A, 1'b1, 1'b1, 8'h91, 2, 2};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst = 1'b0; start = 1'b0; pc = 8'h00; instr_ready = 1'b1;

        // Reset with random inputs
        repeat (4) begin
            start       = 1'($urandom_range(0, 1));
            pc          = 8'($urandom_range(0, 255));
            instr_ready = 1'($urandom_range(0, 1));
            step();
            check("reset_outputs", {ld, mem_req, instr_valid, halted, ld_add, mem_addr, instr, issue_cnt}, 64'd0);
        end
        start = 1'b0; instr_ready = 1'b1; pc = 8'h0A;
        rst = 1'b1;
        repeat (10) begin
            step();
            check("post_reset_quiet", {mem_req, ld}, 2'b00);
        end

        // Sequential fetch from IDLE: 0A, 0B, then halt at 0C
        mem[8'h0A] = 16'h1234; mem[8'h0B] = 16'h2345; mem[8'h0C] = 16'hE000;
        q_addr.push_back(8'h0A); q_addr.push_back(8'h0B); q_addr.push_back(8'h0C);
        q_instr.push_back(16'h1234); q_instr.push_back(16'h2345);
        q_ld.push_back(8'h0B); q_ld.push_back(8'h0C);
        exp_cnt = exp_cnt + 8'd2;
        start_pc(8'h0A);
        wait_halted(n);
        check("seq_cycles", n, 7);
        after_halt("seq");

        // Table of single-instruction runs, each ending on a halt word
        for (int r = 0; r < 7; r++) begin
            mem[rows[r].pc] = rows[r].word;
            q_addr.push_back(rows[r].pc);
            if (rows[r].issue) begin
                q_instr.push_back(rows[r].word);
                exp_cnt = exp_cnt + 8'd1;
            end
            if (rows[r].has_ld) begin
                mem[rows[r].ld_add] = 16'hE000;
                q_ld.push_back(rows[r].ld_add);
                q_addr.push_back(rows[r].ld_add);
            end
            mem_wait    = rows[r].wait_n;
            instr_ready = (rows[r].rdy_dly == 0);
            start_pc(rows[r].pc);
            check("start_clears_halted", halted, 0);
            if (rows[r].rdy_dly > 0) begin
                n = 0;
                while (!instr_valid && n < 50) begin
                    step();
                    n++;
                end
                for (int k = 0; k < rows[r].rdy_dly; k++) begin
                    check("stall_hold", {instr_valid, instr, ld}, {1'b1, rows[r].word, 1'b0});
                    if (k < rows[r].rdy_dly - 1) step();
                end
                instr_ready = 1'b1;
            end
            wait_halted(n);
            after_halt("row");
        end
        mem_wait = 0;

        // Reset in the middle of a waiting fetch
        mem_wait = 5;
        mem[8'h70] = 16'h4444;
        q_addr.push_back(8'h70);
        start_pc(8'h70);
        step();
        check("mid_fetch_req", mem_req, 1);
        q_addr.delete(); q_ld.delete(); q_instr.delete();
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", {ld, mem_req, instr_valid, halted, ld_add, mem_addr, instr, issue_cnt}, 64'd0);
        exp_cnt  = 8'd0;
        mem_wait = 0;
        step();
        step();
        rst = 1'b1;
        step();
        check("mid_reset_idle", {mem_req, ld}, 2'b00);
        mem[8'h25] = 16'h0101; mem[8'h26] = 16'hE000;
        q_addr.push_back(8'h25); q_addr.push_back(8'h26);
        q_instr.push_back(16'h0101); q_ld.push_back(8'h26);
        exp_cnt = 8'd1;
        start_pc(8'h25);
        wait_halted(n);
        after_halt("after_reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
